eltwise_addsub_vec: RTL and testbench
=====================================

ELTWISE_ADDSUB_VEC -- requirements
Module: eltwise_addsub_vec

Interface
REQ-001 SHALL have parameter LANES, default 4, number of int8 element lanes processed per beat.
REQ-002 SHALL have parameter OFIFO_DEPTH, default 16, output FIFO depth in beats (power of two, >= PIPE_LAT+1).
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: cfg_we  in  1  config write strobe; cfg_op  in  2  00=ADD, 01=SUB, 10=RSUB (in2-in1), 11 reserved; cfg_bcast  in  1  broadcast lane 0 of in2 to all lanes.
REQ-005 SHALL have ports: cfg_in1_offset, cfg_in2_offset, cfg_left_shift, cfg_in1_mult, cfg_in2_mult, cfg_in1_shift, cfg_in2_shift, cfg_out_mult, cfg_out_shift, cfg_out_offset, cfg_act_min, cfg_act_max  in  32 each  quantization parameters (signed except left_shift).
REQ-006 SHALL have ports: cfg_err  out  1  one-cycle pulse, rejected cfg_we; busy  out  1  beats outstanding.
REQ-007 SHALL have ports: in_valid  in  1; in_ready  out  1; in1  in  8*LANES; in2  in  8*LANES (lane i = bits 8i+7:8i, signed).
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  8*LANES; out_last  out  1; in_last  in  1  end-of-tensor marker carried with beat.

Function
REQ-009 SHALL accept a config only when cfg_we=1 and busy=0; cfg_we with busy=1 SHALL be ignored and pulse cfg_err next cycle.
REQ-010 SHALL transfer an input beat when in_valid and in_ready are both 1 in the same cycle; out beat on out_valid and out_ready.
REQ-011 Per lane: a=(in1+in1_offset)<<left_shift, b=(in2+in2_offset)<<left_shift, each 32-bit signed; b uses in2 lane 0 when bcast=1.
REQ-012 Per lane: sa=MQM(a,in1_mult,in1_shift), sb=MQM(b,in2_mult,in2_shift); r = sa+sb / sa-sb / sb-sa per cfg_op, 32-bit wrap.
REQ-013 Per lane: y=MQM(r,out_mult,out_shift)+out_offset, clamped to [act_min,act_max], low 8 bits output.
REQ-014 Op 11 SHALL behave as ADD.
REQ-015 Datapath latency input-accept to FIFO-write SHALL be fixed PIPE_LAT = 4 + 2*MQM_LAT cycles, one beat per cycle, no bubbles.
REQ-016 in_last SHALL travel with its beat and appear as out_last on the same output beat.
REQ-017 Credit counter cnt (beats in pipeline + FIFO) SHALL increment on input accept, decrement on output accept, unchanged on simultaneous both; in_ready = (cnt < OFIFO_DEPTH).
REQ-018 FIFO SHALL never overflow; out_valid = FIFO non-empty; FIFO read/write pointers wrap modulo OFIFO_DEPTH; simultaneous read and write on full or empty FIFO SHALL be legal.
REQ-019 busy = (cnt != 0).
REQ-020 Output data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-021 On rst low: cnt, FIFO pointers, pipeline valids, out_valid, out_last, cfg_err, busy = 0; out_data = 0; all config registers = 0; in_ready = 1 after release.
REQ-022 Reset mid-operation SHALL discard all in-flight beats with no output emitted.

Structure
REQ-023 Package SHALL hold OP_ADD/OP_SUB/OP_RSUB encodings, MQM_LAT, PIPE_LAT, INT8_SIZE, INT32_SIZE.
REQ-024 Per-lane arithmetic SHALL be sub-module eltwise_lane (instantiated LANES times), itself using the existing MultiplyByQuantizedMultiplierSmallerThanOneExp three times; control, credit, FIFO in top.

Verification (all mults 0x40000000, shifts 0, left_shift 1, offsets 0, act [-128,127], LANES=4)
REQ-025 ADD: in1=20, in2=6 all lanes -> out 13 per lane, PIPE_LAT+1 cycles later.
REQ-026 SUB: in1=20, in2=6 -> 7; RSUB -> -7; bcast=1, in2 lanes {6,50,50,50} -> all lanes 7 (SUB).
REQ-027 Clamp: ADD, out_offset=120, in1=20, in2=6 -> 127; act_max=100 -> 100.
REQ-028 Backpressure: out_ready=0, stream 20 beats -> exactly 16 accepted, in_ready=0, then out_ready=1 -> all 16 out in order, no loss/duplication, out_last on beat tagged in_last.
REQ-029 cfg_we while busy=1 -> cfg_err pulse, results use old config; reset asserted with 5 beats in flight -> no out_valid after release, busy=0.

Source files
------------

// File: rtl/eltwise_addsub_vec_pkg.sv
// Shared definitions for the element-wise int8 add/sub vector engine:
// operation encodings, pipeline latencies, element sizes and the config record.
package eltwise_addsub_vec_pkg;

    localparam int INT8_SIZE  = 8;
    localparam int INT32_SIZE = 32;

    // Latency of one MultiplyByQuantizedMultiplierSmallerThanOneExp instance.
    localparam int MQM_LAT  = 2;
    // Input register + offset/shift + add/sub + clamp stages, plus two MQM passes.
    localparam int PIPE_LAT = 4 + 2 * MQM_LAT;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_RSUB = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef struct packed {
        op_e                     op;
        logic                    bcast;
        logic [INT32_SIZE-1:0]   in1Offset;
        logic [INT32_SIZE-1:0]   in2Offset;
        logic [INT32_SIZE-1:0]   leftShift;
        logic [INT32_SIZE-1:0]   in1Mult;
        logic [INT32_SIZE-1:0]   in2Mult;
        logic [INT32_SIZE-1:0]   in1Shift;
        logic [INT32_SIZE-1:0]   in2Shift;
        logic [INT32_SIZE-1:0]   outMult;
        logic [INT32_SIZE-1:0]   outShift;
        logic [INT32_SIZE-1:0]   outOffset;
        logic [INT32_SIZE-1:0]   actMin;
        logic [INT32_SIZE-1:0]   actMax;
    } cfg_t;

endpackage

// File: rtl/MultiplyByQuantizedMultiplierSmallerThanOneExp.sv
// Fixed-point requantization: saturating rounding doubling high multiply
// followed by a rounding (half away from zero) right shift by -shift.
// Two register stages; positive shifts act as zero, shifts below -31 as -31.
module MultiplyByQuantizedMultiplierSmallerThanOneExp (
    input  logic               clk,
    input  logic signed [31:0] x_i,
    input  logic signed [31:0] mult_i,
    input  logic signed [31:0] shift_i,
    output logic signed [31:0] y_o
);

    logic signed [63:0] prod_d, prod_q;
    logic               sat_d, sat_q;
    logic        [4:0]  rshift_d, rshift_q;
    logic signed [31:0] negShift;

    logic signed [63:0] nudge, sum, hi64;
    logic signed [31:0] hm, y_d, y_q;
    logic        [31:0] mask, rem, thr;

    // Stage 1 operands: full 64-bit product, the single overflow case, and the right-shift amount.
    always_comb begin
        prod_d   = $signed({{32{x_i[31]}}, x_i}) * $signed({{32{mult_i[31]}}, mult_i});
        sat_d    = (x_i == 32'sh80000000) && (mult_i == 32'sh80000000);
        negShift = -shift_i;
        if (shift_i > 32'sd0) begin
            rshift_d = 5'd0;
        end else if (shift_i < -32'sd31) begin
            rshift_d = 5'd31;
        end else begin
            rshift_d = negShift[4:0];
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        prod_q   <= prod_d;
        sat_q    <= sat_d;
        rshift_q <= rshift_d;
    end

    // Stage 2: round the product to its high word (truncating toward zero after the nudge), then divide by 2^rshift with rounding.
    always_comb begin
        nudge = (prod_q >= 64'sd0) ? 64'sh40000000 : (64'sd1 - 64'sh40000000);
        sum   = prod_q + nudge;
        hi64  = (sum >= 64'sd0) ? (sum >>> 31) : ((sum + 64'sh7FFFFFFF) >>> 31);
        hm    = sat_q ? 32'sh7FFFFFFF : hi64[31:0];
        mask  = (32'h1 << rshift_q) - 32'h1;
        rem   = hm & mask;
        thr   = (mask >> 1) + {31'b0, hm[31]};
        y_d   = (hm >>> rshift_q) + $signed({31'b0, (rem > thr)});
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        y_q <= y_d;
    end

    assign y_o = y_q;

endmodule

// File: rtl/eltwise_addsub_vec_lane.sv
// One int8 lane of the add/sub engine: offset and pre-shift both inputs,
// requantize each, combine per the op, requantize the result, add the
// output offset and clamp to the activation range.
module eltwise_lane
    import eltwise_addsub_vec_pkg::*;
(
    input  logic                 clk,
    input  cfg_t                 cfg_i,
    input  logic [INT8_SIZE-1:0] in1_i,
    input  logic [INT8_SIZE-1:0] in2_i,
    output logic [INT8_SIZE-1:0] out_o
);

    logic signed [31:0] a_d, b_d, a_q, b_q;
    logic signed [31:0] sa, sb, r_d, r_q;
    logic signed [31:0] outScaled, sum, y_d;
    logic        [7:0]  y_q;

    // Sign-extend, add input offsets and apply the shared left shift (32-bit wrap).
    always_comb begin
        a_d = ({{24{in1_i[7]}}, in1_i} + cfg_i.in1Offset) << cfg_i.leftShift;
        b_d = ({{24{in2_i[7]}}, in2_i} + cfg_i.in2Offset) << cfg_i.leftShift;
    end

    // Register the pre-scaled operands.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    MultiplyByQuantizedMultiplierSmallerThanOneExp uMqmIn1 (
        .clk     (clk),
        .x_i     (a_q),
        .mult_i  (cfg_i.in1Mult),
        .shift_i (cfg_i.in1Shift),
        .y_o     (sa)
    );

    MultiplyByQuantizedMultiplierSmallerThanOneExp uMqmIn2 (
        .clk     (clk),
        .x_i     (b_q),
        .mult_i  (cfg_i.in2Mult),
        .shift_i (cfg_i.in2Shift),
        .y_o     (sb)
    );

    // Combine the scaled operands; the reserved op code falls back to add.
    always_comb begin
        r_d = sa + sb;
        case (cfg_i.op)
            OP_SUB:  r_d = sa - sb;
            OP_RSUB: r_d = sb - sa;
            default: r_d = sa + sb;
        endcase
    end

    // Register the raw combined result.
    always_ff @(posedge clk) begin
        r_q <= r_d;
    end

    MultiplyByQuantizedMultiplierSmallerThanOneExp uMqmOut (
        .clk     (clk),
        .x_i     (r_q),
        .mult_i  (cfg_i.outMult),
        .shift_i (cfg_i.outShift),
        .y_o     (outScaled)
    );

    // Add the output offset and clamp into [actMin, actMax].
    always_comb begin
        sum = outScaled + $signed(cfg_i.outOffset);
        y_d = sum;
        if (sum < $signed(cfg_i.actMin)) begin
            y_d = $signed(cfg_i.actMin);
        end
        if (sum > $signed(cfg_i.actMax)) begin
            y_d = $signed(cfg_i.actMax);
        end
    end

    // Register the clamped int8 result.
    always_ff @(posedge clk) begin
        y_q <= y_d[7:0];
    end

    assign out_o = y_q;

endmodule

// File: rtl/eltwise_addsub_vec.sv
// Element-wise int8 add/sub over LANES lanes with a fixed-latency datapath,
// credit-based input flow control and an output FIFO that absorbs every
// beat in flight, so the pipeline itself never has to stall.
module eltwise_addsub_vec
    import eltwise_addsub_vec_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int OFIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_op,
    input  logic                 cfg_bcast,
    input  logic [31:0]          cfg_in1_offset,
    input  logic [31:0]          cfg_in2_offset,
    input  logic [31:0]          cfg_left_shift,
    input  logic [31:0]          cfg_in1_mult,
    input  logic [31:0]          cfg_in2_mult,
    input  logic [31:0]          cfg_in1_shift,
    input  logic [31:0]          cfg_in2_shift,
    input  logic [31:0]          cfg_out_mult,
    input  logic [31:0]          cfg_out_shift,
    input  logic [31:0]          cfg_out_offset,
    input  logic [31:0]          cfg_act_min,
    input  logic [31:0]          cfg_act_max,
    output logic                 cfg_err,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in1,
    input  logic [8*LANES-1:0]   in2,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_last
);

    localparam int AW = $clog2(OFIFO_DEPTH);
    localparam int CW = AW + 1;

    cfg_t                cfg_q, cfgIn;
    logic                cfgErr_q;
    logic                inAccept, outAccept;
    logic [CW-1:0]       cnt_d, cnt_q;
    logic [8*LANES-1:0]  in1_q, in2_q, laneOut;
    logic [PIPE_LAT-1:0] vld_q, lst_q;

    logic [8*LANES:0]    mem [OFIFO_DEPTH];
    logic [AW-1:0]       wrPtr_q, rdPtr_q;
    logic [CW-1:0]       fifoCnt_q;
    logic                fifoWr;
    logic [8*LANES:0]    rdWord;

    assign inAccept  = in_valid && in_ready;
    assign outAccept = out_valid && out_ready;
    assign in_ready  = (cnt_q < CW'(OFIFO_DEPTH));
    assign busy      = (cnt_q != '0);
    assign cfg_err   = cfgErr_q;

    // Gather the config ports into one record.
    always_comb begin
        cfgIn           = '0;
        cfgIn.op        = op_e'(cfg_op);
        cfgIn.bcast     = cfg_bcast;
        cfgIn.in1Offset = cfg_in1_offset;
        cfgIn.in2Offset = cfg_in2_offset;
        cfgIn.leftShift = cfg_left_shift;
        cfgIn.in1Mult   = cfg_in1_mult;
        cfgIn.in2Mult   = cfg_in2_mult;
        cfgIn.in1Shift  = cfg_in1_shift;
        cfgIn.in2Shift  = cfg_in2_shift;
        cfgIn.outMult   = cfg_out_mult;
        cfgIn.outShift  = cfg_out_shift;
        cfgIn.outOffset = cfg_out_offset;
        cfgIn.actMin    = cfg_act_min;
        cfgIn.actMax    = cfg_act_max;
    end

    // Config only changes with nothing in flight; a write while busy is dropped and flagged for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q    <= '0;
            cfgErr_q <= 1'b0;
        end else begin
            cfgErr_q <= cfg_we && busy;
            if (cfg_we && !busy) begin
                cfg_q <= cfgIn;
            end
        end
    end

    // Credits cover beats in the pipeline plus beats in the FIFO.
    always_comb begin
        cnt_d = cnt_q;
        case ({inAccept, outAccept})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Capture accepted operands and shift the valid/last tags alongside the lane pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1_q <= '0;
            in2_q <= '0;
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            if (inAccept) begin
                in1_q <= in1;
                in2_q <= in2;
            end
            vld_q <= {vld_q[PIPE_LAT-2:0], inAccept};
            lst_q <= {lst_q[PIPE_LAT-2:0], inAccept && in_last};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : gLane
        logic [7:0] in2Lane;
        assign in2Lane = cfg_q.bcast ? in2_q[7:0] : in2_q[8*i +: 8];

        eltwise_lane uLane (
            .clk   (clk),
            .cfg_i (cfg_q),
            .in1_i (in1_q[8*i +: 8]),
            .in2_i (in2Lane),
            .out_o (laneOut[8*i +: 8])
        );
    end

    assign fifoWr = vld_q[PIPE_LAT-1];

    // FIFO storage; credits guarantee a free slot whenever a beat leaves the pipeline.
    always_ff @(posedge clk) begin
        if (fifoWr) begin
            mem[wrPtr_q] <= {lst_q[PIPE_LAT-1], laneOut};
        end
    end

    // FIFO pointers and occupancy; read and write in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            fifoCnt_q <= '0;
        end else begin
            if (fifoWr) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (outAccept) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({fifoWr, outAccept})
                2'b10:   fifoCnt_q <= fifoCnt_q + CW'(1);
                2'b01:   fifoCnt_q <= fifoCnt_q - CW'(1);
                default: fifoCnt_q <= fifoCnt_q;
            endcase
        end
    end

    assign rdWord    = mem[rdPtr_q];
    assign out_valid = (fifoCnt_q != '0);
    assign out_data  = out_valid ? rdWord[8*LANES-1:0] : '0;
    assign out_last  = out_valid ? rdWord[8*LANES] : 1'b0;

endmodule

// File: tb/tb_eltwise_addsub_vec.sv
// Self-checking bench for eltwise_addsub_vec: directed quantized add/sub
// cases, clamping, backpressure, config rejection, mid-stream reset and a
// randomized stream scored against an arithmetic reference model.
module tb_eltwise_addsub_vec;
   import eltwise_addsub_vec_pkg::*;

   localparam int LANES = 4;
   localparam int DEPTH = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               cfg_we = 1'b0;
   logic [1:0]         cfg_op = 2'b00;
   logic               cfg_bcast = 1'b0;
   logic [31:0]        cfg_in1_offset, cfg_in2_offset, cfg_left_shift, cfg_in1_mult;
   logic [31:0]        cfg_in2_mult, cfg_in1_shift, cfg_in2_shift, cfg_out_mult;
   logic [31:0]        cfg_out_shift, cfg_out_offset, cfg_act_min, cfg_act_max;
   logic               cfg_err, busy;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [8*LANES-1:0] in1 = '0;
   logic [8*LANES-1:0] in2 = '0;
   logic               in_last = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [8*LANES-1:0] out_data;
   logic               out_last;

   int checks = 0;
   int errors = 0;
   int acceptCount = 0;
   int outCount = 0;

   typedef struct {
      logic [8*LANES-1:0] data;
      logic               last;
   } beat_t;
   beat_t expQ[$];

   // Reference copy of the configuration the DUT is known to hold.
   int mOp, mBcast, mIn1Off, mIn2Off, mLeftShift, mIn1Mult, mIn2Mult;
   int mIn1Shift, mIn2Shift, mOutMult, mOutShift, mOutOffset, mActMin, mActMax;

   eltwise_addsub_vec #(.LANES(LANES), .OFIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_bcast(cfg_bcast),
      .cfg_in1_offset(cfg_in1_offset), .cfg_in2_offset(cfg_in2_offset),
      .cfg_left_shift(cfg_left_shift), .cfg_in1_mult(cfg_in1_mult),
      .cfg_in2_mult(cfg_in2_mult), .cfg_in1_shift(cfg_in1_shift),
      .cfg_in2_shift(cfg_in2_shift), .cfg_out_mult(cfg_out_mult),
      .cfg_out_shift(cfg_out_shift), .cfg_out_offset(cfg_out_offset),
      .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
      .cfg_err(cfg_err), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case some bounded wait was missed.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Quantized multiply: rounded doubling high product, then round-half-away-from-zero divide by 2^-shift.
   function automatic int mqm(int x, int m, int s);
      longint ab, q, p;
      int     hm, e;
      if (x == int'(32'h80000000) && m == int'(32'h80000000)) begin
         hm = int'(32'h7FFFFFFF);
      end else begin
         ab = longint'(x) * longint'(m);
         if (ab >= 0) q = (ab + 64'sd1073741824) / 64'sd2147483648;
         else         q = (ab + 64'sd1 - 64'sd1073741824) / 64'sd2147483648;
         hm = int'(q);
      end
      e = (s > 0) ? 0 : ((s < -31) ? 31 : -s);
      if (e == 0) return hm;
      p = longint'(1) <<< (e - 1);
      if (hm >= 0) return int'((longint'(hm) + p) >>> e);
      return -int'((-longint'(hm) + p) >>> e);
   endfunction

   // Whole-beat expected output from the reference configuration.
   function automatic logic [8*LANES-1:0] model(logic [8*LANES-1:0] v1, logic [8*LANES-1:0] v2);
      logic [8*LANES-1:0] res;
      int x1, x2, a, b, sa, sb, r, y;
      res = '0;
      for (int l = 0; l < LANES; l++) begin
         x1 = int'($signed(v1[8*l +: 8]));
         x2 = (mBcast != 0) ? int'($signed(v2[7:0])) : int'($signed(v2[8*l +: 8]));
         a  = (x1 + mIn1Off) << mLeftShift;
         b  = (x2 + mIn2Off) << mLeftShift;
         sa = mqm(a, mIn1Mult, mIn1Shift);
         sb = mqm(b, mIn2Mult, mIn2Shift);
         if (mOp == 1)      r = sa - sb;
         else if (mOp == 2) r = sb - sa;
         else               r = sa + sb;
         y = mqm(r, mOutMult, mOutShift) + mOutOffset;
         if (y < mActMin) y = mActMin;
         if (y > mActMax) y = mActMax;
         res[8*l +: 8] = y[7:0];
      end
      return res;
   endfunction

   task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Scoreboard: record accepted beats, compare every beat that leaves the DUT.
   always @(negedge clk) begin
      beat_t e;
      if (rst && in_valid && in_ready) begin
         e.data = model(in1, in2);
         e.last = in_last;
         expQ.push_back(e);
         acceptCount++;
      end
      if (rst && out_valid && out_ready) begin
         outCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_out", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_beat", {out_last, out_data}, {e.last, e.data});
         end
      end
   end

   task automatic setDefaultCfg(logic [1:0] op, logic bc);
      cfg_op = op;             cfg_bcast = bc;
      cfg_in1_offset = 0;      cfg_in2_offset = 0;      cfg_left_shift = 1;
      cfg_in1_mult = 32'h40000000; cfg_in2_mult = 32'h40000000; cfg_out_mult = 32'h40000000;
      cfg_in1_shift = 0;       cfg_in2_shift = 0;       cfg_out_shift = 0;
      cfg_out_offset = 0;      cfg_act_min = -128;      cfg_act_max = 127;
   endtask

   // Pulse cfg_we; an accepted write also updates the reference configuration.
   task automatic applyConfig(logic expErr);
      cfg_we = 1'b1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      checkOutput("cfg_err", cfg_err, expErr);
      @(posedge clk); #1;
      checkOutput("cfg_err_clear", cfg_err, 0);
      if (!expErr) begin
         mOp = int'(cfg_op); mBcast = int'(cfg_bcast);
         mIn1Off = cfg_in1_offset; mIn2Off = cfg_in2_offset; mLeftShift = cfg_left_shift;
         mIn1Mult = cfg_in1_mult; mIn2Mult = cfg_in2_mult; mOutMult = cfg_out_mult;
         mIn1Shift = cfg_in1_shift; mIn2Shift = cfg_in2_shift; mOutShift = cfg_out_shift;
         mOutOffset = cfg_out_offset; mActMin = cfg_act_min; mActMax = cfg_act_max;
      end
   endtask

   // Present one beat and hold it until the scoreboard records its acceptance.
   task automatic applyStimulus(logic [8*LANES-1:0] v1, logic [8*LANES-1:0] v2, logic last);
      int start, n;
      start = acceptCount;
      n = 0;
      in1 = v1; in2 = v2; in_last = last; in_valid = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (acceptCount == start && n < 100);
      in_valid = 1'b0; in_last = 1'b0;
      if (acceptCount == start) checkOutput("accept_timeout", 1, 0);
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || busy) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain_done", expQ.size(), 0);
   endtask

   // Single beat with out_ready high: check arrival time and value, then drain.
   task automatic runDirected(string tag, logic [8*LANES-1:0] v1, logic [8*LANES-1:0] v2,
                              logic [8*LANES-1:0] expected);
      int lat;
      out_ready = 1'b1;
      applyStimulus(v1, v2, 1'b0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      // The beat is written PIPE_LAT edges after acceptance and leaves on the next edge.
      checkOutput({tag, "_latency"}, lat, PIPE_LAT);
      checkOutput({tag, "_value"}, out_data, expected);
      waitDrain();
   endtask

   initial begin
      int base, outBase, k, sawValid;
      logic [8*LANES-1:0] bp1 [20];
      logic [8*LANES-1:0] bp2 [20];

      setDefaultCfg(2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_last", out_last, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_cfg_err", cfg_err, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_in_ready", in_ready, 1);

      $display("[TB] directed add/sub/rsub/broadcast");
      setDefaultCfg(2'b00, 1'b0); applyConfig(1'b0);
      runDirected("add", 32'h14141414, 32'h06060606, 32'h0D0D0D0D);
      setDefaultCfg(2'b01, 1'b0); applyConfig(1'b0);
      runDirected("sub", 32'h14141414, 32'h06060606, 32'h07070707);
      setDefaultCfg(2'b10, 1'b0); applyConfig(1'b0);
      runDirected("rsub", 32'h14141414, 32'h06060606, 32'hF9F9F9F9);
      setDefaultCfg(2'b01, 1'b1); applyConfig(1'b0);
      runDirected("bcast_sub", 32'h14141414, 32'h32323206, 32'h07070707);
      setDefaultCfg(2'b11, 1'b0); applyConfig(1'b0);
      runDirected("op11_add", 32'h14141414, 32'h06060606, 32'h0D0D0D0D);

      $display("[TB] clamping");
      setDefaultCfg(2'b00, 1'b0); cfg_out_offset = 120; applyConfig(1'b0);
      runDirected("clamp_127", 32'h14141414, 32'h06060606, 32'h7F7F7F7F);
      cfg_act_max = 100; applyConfig(1'b0);
      runDirected("clamp_100", 32'h14141414, 32'h06060606, 32'h64646464);

      $display("[TB] config write while busy");
      setDefaultCfg(2'b00, 1'b0); applyConfig(1'b0);
      out_ready = 1'b0;
      applyStimulus(32'h14141414, 32'h06060606, 1'b0);
      applyStimulus(32'h01020304, 32'h05060708, 1'b1);
      cfg_op = 2'b01; cfg_out_offset = 50;
      applyConfig(1'b1);
      out_ready = 1'b1;
      waitDrain();

      $display("[TB] backpressure");
      setDefaultCfg(2'b00, 1'b0); applyConfig(1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bp1[i] = $urandom;
         bp2[i] = $urandom;
      end
      base = acceptCount;
      outBase = outCount;
      for (int i = 0; i < 20; i++) begin
         k = acceptCount - base;
         in1 = bp1[k]; in2 = bp2[k];
         in_last = (k == 7 || k == 15);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      checkOutput("bp_accepted", acceptCount - base, DEPTH);
      checkOutput("bp_in_ready", in_ready, 0);
      repeat (PIPE_LAT + 2) @(posedge clk);
      #1;
      checkOutput("bp_out_valid", out_valid, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_hold_data", out_data, expQ[0].data);
      checkOutput("bp_hold_last", out_last, expQ[0].last);
      out_ready = 1'b1;
      waitDrain();
      checkOutput("bp_delivered", outCount - outBase, DEPTH);

      $display("[TB] randomized stream");
      for (int c = 0; c < 3; c++) begin
         cfg_op = 2'($urandom_range(0, 3));
         cfg_bcast = 1'($urandom_range(0, 1));
         cfg_in1_offset = $urandom_range(0, 40) - 20;
         cfg_in2_offset = $urandom_range(0, 40) - 20;
         cfg_left_shift = $urandom_range(0, 12);
         cfg_in1_mult = $urandom_range(32'h7FFFFFFF, 32'h40000000);
         cfg_in2_mult = $urandom_range(32'h7FFFFFFF, 32'h40000000);
         cfg_out_mult = $urandom_range(32'h7FFFFFFF, 32'h40000000);
         cfg_in1_shift = -$urandom_range(0, 4);
         cfg_in2_shift = -$urandom_range(0, 4);
         cfg_out_shift = -$urandom_range(0, 6);
         cfg_out_offset = $urandom_range(0, 40) - 20;
         cfg_act_min = -$urandom_range(60, 128);
         cfg_act_max = $urandom_range(60, 127);
         applyConfig(1'b0);
         for (int i = 0; i < 150; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in1 = $urandom; in2 = $urandom;
            in_last = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
         end
         in_valid = 1'b0; in_last = 1'b0;
         out_ready = 1'b1;
         waitDrain();
      end

      $display("[TB] reset with beats in flight");
      setDefaultCfg(2'b00, 1'b0); applyConfig(1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(32'h14141414, 32'h06060606, 1'b0);
      rst = 1'b0;
      expQ.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      sawValid = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) sawValid = 1;
      end
      checkOutput("rst_no_output", sawValid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
